// File: rtl/reg_file_mp.sv
// Multi-port integer register file: two registered read ports and one byte-masked write port.
// x0 reads as zero, and a scrub FSM clears every entry after reset. Define REG_FILE_BYPASS_EN to
// forward a same-edge write to the read ports.
module reg_file_mp #(
  parameter int unsigned REG_IDX_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter int unsigned REG_COUNT     = 32
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  output logic                             ready,
  input  logic                             rs1_en,
  input  logic [REG_IDX_WIDTH-1:0]         rs1_idx,
  output logic [DATA_WIDTH-1:0]            rs1_data,
  input  logic                             rs2_en,
  input  logic [REG_IDX_WIDTH-1:0]         rs2_idx,
  output logic [DATA_WIDTH-1:0]            rs2_data,
  output logic                             rs_valid,
  input  logic                             rd_we,
  input  logic [REG_IDX_WIDTH-1:0]         rd_idx,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] rd_be,
  input  logic [DATA_WIDTH-1:0]            rd_data
);

  localparam int unsigned NumLanes = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned CntW     = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(REG_COUNT - 1);

  typedef enum logic [0:0] {StScrub, StRun} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       scrub_cnt_q, scrub_cnt_d;
  logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;
  logic                  rs_valid_q, rs_valid_d;

  logic [DATA_WIDTH-1:0] mem [REG_COUNT];

  logic [CntW-1:0]       rs1_addr, rs2_addr, rd_addr;
  logic [DATA_WIDTH-1:0] rd_old, rd_merged;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] rs1_rdata, rs2_rdata;
  logic                  mem_we;
  logic [CntW-1:0]       mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Entry 0 is hardwired zero; entries at or above REG_COUNT do not exist.
  function automatic logic idx_ok(input logic [REG_IDX_WIDTH-1:0] idx);
    return (idx != '0) && (32'(idx) < REG_COUNT);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [NumLanes-1:0]   be);
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int unsigned b = 0; b < NumLanes; b++) begin
      if (be[b]) res[b*BYTE_WIDTH +: BYTE_WIDTH] = new_w[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return res;
  endfunction

  // Truncation is safe: an index that passes idx_ok is below REG_COUNT.
  assign rs1_addr = rs1_idx[CntW-1:0];
  assign rs2_addr = rs2_idx[CntW-1:0];
  assign rd_addr  = rd_idx[CntW-1:0];

  assign rd_old    = mem[rd_addr];
  assign rd_merged = merge_lanes(rd_old, rd_data, rd_be);
  assign rd_fire   = (state_q == StRun) && rd_we && idx_ok(rd_idx) && (rd_be != '0);

  always_comb begin
    rs1_rdata = '0;
    rs2_rdata = '0;
    if (idx_ok(rs1_idx)) begin
`ifdef REG_FILE_BYPASS_EN
      if (rd_fire && (rs1_idx == rd_idx)) rs1_rdata = rd_merged;
      else                                rs1_rdata = mem[rs1_addr];
`else
      rs1_rdata = mem[rs1_addr];
`endif
    end
    if (idx_ok(rs2_idx)) begin
`ifdef REG_FILE_BYPASS_EN
      if (rd_fire && (rs2_idx == rd_idx)) rs2_rdata = rd_merged;
      else                                rs2_rdata = mem[rs2_addr];
`else
      rs2_rdata = mem[rs2_addr];
`endif
    end
  end

  // Single write port shared between the scrubber and the rd path.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = rd_addr;
    mem_wdata = rd_merged;
    if (state_q == StScrub) begin
      mem_we    = 1'b1;
      mem_waddr = scrub_cnt_q;
      mem_wdata = '0;
    end else if (rd_fire) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    state_d     = state_q;
    scrub_cnt_d = scrub_cnt_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    rs_valid_d  = 1'b0;
    case (state_q)
      StScrub: begin
        scrub_cnt_d = scrub_cnt_q + 1'b1;
        rs1_data_d  = '0;
        rs2_data_d  = '0;
        if (scrub_cnt_q == LastIdx) state_d = StRun;
      end
      StRun: begin
        if (rs1_en) rs1_data_d = rs1_rdata;
        if (rs2_en) rs2_data_d = rs2_rdata;
        rs_valid_d = rs1_en | rs2_en;
      end
      default: state_d = StScrub;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= StScrub;
      scrub_cnt_q <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rs_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      scrub_cnt_q <= scrub_cnt_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      rs_valid_q  <= rs_valid_d;
    end
  end

  assign ready    = (state_q == StRun);
  assign rs1_data = rs1_data_q;
  assign rs2_data = rs2_data_q;
  assign rs_valid = rs_valid_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: read requests push expected data, a negedge monitor
// pops and compares whenever rs_valid is presented.
module tb_reg_file_mp;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        ready;
  logic        rs1_en, rs2_en, rs_valid;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [31:0] rs1_data, rs2_data, rd_data;
  logic        rd_we;
  logic [3:0]  rd_be;

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  reg_file_mp dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .rs1_en    (rs1_en),
    .rs1_idx   (rs1_idx),
    .rs1_data  (rs1_data),
    .rs2_en    (rs2_en),
    .rs2_idx   (rs2_idx),
    .rs2_data  (rs2_data),
    .rs_valid  (rs_valid),
    .rd_we     (rd_we),
    .rd_idx    (rd_idx),
    .rd_be     (rd_be),
    .rd_data   (rd_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Monitor: every presented read result must match the oldest expectation.
  always @(negedge sys_clk) begin
    if (rs_valid) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: got rs_valid=1 with rs1=%h rs2=%h, required no output",
                 rs1_data, rs2_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rs1_data !== e.r1 || rs2_data !== e.r2) begin
          n_err++;
          $display("FAIL %s: got rs1=%h rs2=%h, required rs1=%h rs2=%h",
                   e.name, rs1_data, rs2_data, e.r1, e.r2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] idx, input logic [3:0] be, input logic [31:0] data);
    rd_we = 1'b1; rd_idx = idx; rd_be = be; rd_data = data;
    tick();
    rd_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic e1, input logic [4:0] i1, input logic e2,
                    input logic [4:0] i2, input logic [31:0] x1, input logic [31:0] x2);
    exp_t e;
    rs1_en = e1; rs1_idx = i1; rs2_en = e2; rs2_idx = i2;
    e.name = name; e.r1 = x1; e.r2 = x2;
    q.push_back(e);
    tick();
    rs1_en = 1'b0; rs2_en = 1'b0;
  endtask

  // Write and both reads on the same edge.
  task automatic raw(input string name, input logic [4:0] widx, input logic [3:0] be,
                     input logic [31:0] wdata, input logic [4:0] i1, input logic [4:0] i2,
                     input logic [31:0] x1, input logic [31:0] x2);
    exp_t e;
    rd_we = 1'b1; rd_idx = widx; rd_be = be; rd_data = wdata;
    rs1_en = 1'b1; rs1_idx = i1; rs2_en = 1'b1; rs2_idx = i2;
    e.name = name; e.r1 = x1; e.r2 = x2;
    q.push_back(e);
    tick();
    rd_we = 1'b0; rs1_en = 1'b0; rs2_en = 1'b0;
  endtask

  task automatic reset_scrub(input bit junk);
    sys_rst_n = 1'b0;
    tick();
    check("ready_after_reset", 32'(ready), 32'd0);
    check("rs1_after_reset", rs1_data, 32'd0);
    check("rs2_after_reset", rs2_data, 32'd0);
    check("valid_after_reset", 32'(rs_valid), 32'd0);
    sys_rst_n = 1'b1;
    if (junk) begin
      // Requests during scrub must be ignored.
      rs1_en = 1'b1; rs1_idx = 5'd1; rs2_en = 1'b1; rs2_idx = 5'd1;
      rd_we = 1'b1; rd_idx = 5'd1; rd_be = 4'hF; rd_data = 32'hCAFEF00D;
    end
    for (int k = 1; k <= 32; k++) begin
      tick();
      check("ready_scrub", 32'(ready), (k == 32) ? 32'd1 : 32'd0);
      if (junk) check("rs1_scrub_hold", rs1_data, 32'd0);
    end
    rs1_en = 1'b0; rs2_en = 1'b0; rd_we = 1'b0;
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < 32; i++) rd(name, 1'b1, 5'(i), 1'b1, 5'(31 - i), 32'd0, 32'd0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    rs1_en = 1'b0; rs1_idx = '0; rs2_en = 1'b0; rs2_idx = '0;
    rd_we = 1'b0; rd_idx = '0; rd_be = '0; rd_data = '0;

    reset_scrub(1'b1);
    read_all_zero("scrub_zero");

    wr(5'd5, 4'hF, 32'hDEADBEEF);
    rd("full_write", 1'b1, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);

    wr(5'd7, 4'hF, 32'h11223344);
    wr(5'd7, 4'b0101, 32'hAABBCCDD);
    rd("byte_mask", 1'b1, 5'd7, 1'b1, 5'd0, 32'h11BB33DD, 32'd0);

    wr(5'd0, 4'hF, 32'hFFFFFFFF);
    rd("x0_write_dropped", 1'b1, 5'd0, 1'b1, 5'd5, 32'd0, 32'hDEADBEEF);

    wr(5'd5, 4'h0, 32'h00000000);
    rd("be_zero_no_change", 1'b1, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);

    wr(5'd3, 4'hF, 32'h00000001);
`ifdef REG_FILE_BYPASS_EN
    raw("raw_same_edge", 5'd3, 4'hF, 32'h00000002, 5'd3, 5'd3, 32'h2, 32'h2);
`else
    raw("raw_same_edge", 5'd3, 4'hF, 32'h00000002, 5'd3, 5'd3, 32'h1, 32'h1);
`endif
    rd("raw_followup", 1'b1, 5'd3, 1'b1, 5'd3, 32'h2, 32'h2);

    wr(5'd9, 4'hF, 32'hAAAAAAAA);
`ifdef REG_FILE_BYPASS_EN
    raw("raw_partial", 5'd9, 4'b0011, 32'h55555555, 5'd9, 5'd5, 32'hAAAA5555, 32'hDEADBEEF);
`else
    raw("raw_partial", 5'd9, 4'b0011, 32'h55555555, 5'd9, 5'd5, 32'hAAAAAAAA, 32'hDEADBEEF);
`endif
    rd("partial_followup", 1'b1, 5'd9, 1'b1, 5'd9, 32'hAAAA5555, 32'hAAAA5555);

    rd("hold_rs2", 1'b1, 5'd7, 1'b0, 5'd3, 32'h11BB33DD, 32'hAAAA5555);
    rd("hold_rs1", 1'b0, 5'd3, 1'b1, 5'd5, 32'h11BB33DD, 32'hDEADBEEF);
    tick();
    tick();

    // Reset while in RUN with live data.
    reset_scrub(1'b0);
    rd("run_reset_5_7", 1'b1, 5'd5, 1'b1, 5'd7, 32'd0, 32'd0);
    rd("run_reset_3_9", 1'b1, 5'd3, 1'b1, 5'd9, 32'd0, 32'd0);
    read_all_zero("run_reset_zero");

    // Reset again 10 cycles into a scrub.
    wr(5'd11, 4'hF, 32'h12345678);
    rd("pre_midscrub", 1'b1, 5'd11, 1'b0, 5'd0, 32'h12345678, 32'd0);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    repeat (10) tick();
    check("ready_midscrub", 32'(ready), 32'd0);
    reset_scrub(1'b0);
    read_all_zero("midscrub_zero");

    repeat (3) tick();
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
